// File: rtl/one_wire_slave.sv
// 1-Wire responder: bus-reset detection, presence pulse, Read/Skip/Match ROM
// decoding and a byte-level rx/tx handshake for the function-layer client.
module one_wire_slave #(
    parameter int CLKS_PER_US  = 50,
    parameter int RST_MIN_US   = 400,
    parameter int PRES_WAIT_US = 30,
    parameter int PRES_US      = 120,
    parameter int SAMPLE_US    = 30,
    parameter int TX0_US       = 45
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ow_in,
    output logic        ow_out,
    output logic        ow_oe,
    input  logic [63:0] rom_id,
    output logic        selected,
    output logic        bus_reset,
    output logic [7:0]  rx_byte,
    output logic        rx_dv,
    input  logic [7:0]  tx_byte,
    input  logic        tx_valid,
    output logic        tx_ready
);

    localparam int RST_CYC    = RST_MIN_US * CLKS_PER_US;
    localparam int PW_CYC     = PRES_WAIT_US * CLKS_PER_US;
    localparam int PRES_CYC   = PRES_US * CLKS_PER_US;
    localparam int SAMPLE_CYC = SAMPLE_US * CLKS_PER_US;
    localparam int TX0_CYC    = TX0_US * CLKS_PER_US;
    localparam int PHASE_MAX  = (PW_CYC > PRES_CYC) ? PW_CYC : PRES_CYC;
    localparam int SLOT_MAX   = (SAMPLE_CYC > TX0_CYC) ? SAMPLE_CYC : TX0_CYC;
    localparam int MAX_A      = (PHASE_MAX > SLOT_MAX) ? PHASE_MAX : SLOT_MAX;
    localparam int MAX_ALL    = (RST_CYC > MAX_A) ? RST_CYC : MAX_A;
    localparam int CW         = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] ONE_T       = CW'(1);
    localparam logic [CW-1:0] RST_T       = CW'(RST_CYC);
    localparam logic [CW-1:0] PW_LAST_T   = CW'(PW_CYC - 1);
    localparam logic [CW-1:0] PRES_T      = CW'(PRES_CYC);
    localparam logic [CW-1:0] SAMPLE_T    = CW'(SAMPLE_CYC);
    localparam logic [CW-1:0] TX0_T       = CW'(TX0_CYC);
    localparam logic [CW-1:0] PHASE_MAX_T = CW'(PHASE_MAX);
    localparam logic [CW-1:0] SLOT_MAX_T  = CW'(SLOT_MAX);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_RST_LOW   = 4'd1,
        ST_PRES_WAIT = 4'd2,
        ST_PRESENCE  = 4'd3,
        ST_PRES_REL  = 4'd4,
        ST_ROM_CMD   = 4'd5,
        ST_READ_ROM  = 4'd6,
        ST_MATCH_ROM = 4'd7,
        ST_FUNC      = 4'd8
    } state_t;

    state_t         state_r, state_nx_s;
    logic           ow_s1_r, ow_s2_r, ow_prev_r;
    logic [CW-1:0]  low_cnt_r;
    logic [CW-1:0]  phase_tmr_r;
    logic [CW-1:0]  edge_tmr_r;
    logic           slot_act_r, armed_r, drv_r;
    logic           byte_act_r, func_tx_r;
    logic [6:0]     bit_cnt_r;
    logic [6:0]     rx_sh_r;
    logic [7:0]     tx_sh_r;
    logic           oe_r, selected_r, bus_reset_r, rx_dv_r, tx_ready_r;
    logic [7:0]     rx_byte_r;

    logic           fall_s, rise_s, sat_s;
    logic           slot_state_s, tx_slot_s, tx_bit_s;
    logic           start_s, samp_s, latch_s, drive_s;
    logic           byte_last_s, rom_last_s;
    logic [7:0]     rx_word_s;
    logic           oe_nx_s, selected_nx_s, bus_reset_nx_s, rx_dv_nx_s, tx_ready_nx_s;

    assign ow_out    = 1'b0;
    assign ow_oe     = oe_r;
    assign selected  = selected_r;
    assign bus_reset = bus_reset_r;
    assign rx_byte   = rx_byte_r;
    assign rx_dv     = rx_dv_r;
    assign tx_ready  = tx_ready_r;

    // Two-flop synchroniser plus a delayed copy for edge detection; idle bus is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ow_s1_r   <= 1'b1;
            ow_s2_r   <= 1'b1;
            ow_prev_r <= 1'b1;
        end else begin
            ow_s1_r   <= ow_in;
            ow_s2_r   <= ow_s1_r;
            ow_prev_r <= ow_s2_r;
        end
    end

    // Saturating low-time counter used for bus-reset recognition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            low_cnt_r <= '0;
        end else if (ow_s2_r) begin
            low_cnt_r <= '0;
        end else if (low_cnt_r != RST_T) begin
            low_cnt_r <= low_cnt_r + ONE_T;
        end else begin
            low_cnt_r <= low_cnt_r;
        end
    end

    // Slot qualification and the bit the current slot would transmit.
    always_comb begin
        fall_s       = ow_prev_r & ~ow_s2_r;
        rise_s       = ~ow_prev_r & ow_s2_r;
        sat_s        = (low_cnt_r == RST_T);
        slot_state_s = 1'b0;
        tx_slot_s    = 1'b0;
        tx_bit_s     = 1'b1;
        case (state_r)
            ST_ROM_CMD, ST_MATCH_ROM: begin
                slot_state_s = 1'b1;
            end
            ST_READ_ROM: begin
                slot_state_s = 1'b1;
                tx_slot_s    = 1'b1;
                tx_bit_s     = rom_id[bit_cnt_r[5:0]];
            end
            ST_FUNC: begin
                slot_state_s = 1'b1;
                // At a byte boundary a pending tx byte claims the very next slot.
                if (byte_act_r) begin
                    tx_slot_s = func_tx_r;
                    tx_bit_s  = tx_sh_r[bit_cnt_r[2:0]];
                end else begin
                    tx_slot_s = tx_valid;
                    tx_bit_s  = tx_byte[0];
                end
            end
            default: begin
                slot_state_s = 1'b0;
            end
        endcase
        start_s     = slot_state_s & ~slot_act_r & armed_r & fall_s & ~sat_s;
        samp_s      = slot_act_r & (edge_tmr_r == SAMPLE_T) & ~sat_s;
        latch_s     = (state_r == ST_FUNC) & ~byte_act_r & tx_valid & ~sat_s;
        drive_s     = (start_s & tx_slot_s & ~tx_bit_s) | (drv_r & (edge_tmr_r < TX0_T));
        byte_last_s = (bit_cnt_r[2:0] == 3'd7);
        rom_last_s  = (bit_cnt_r == 7'd63);
        rx_word_s   = {ow_s2_r, rx_sh_r};
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; a saturated low timer overrides everything.
    always_comb begin
        state_nx_s = state_r;
        if (sat_s) begin
            state_nx_s = rise_s ? ST_PRES_WAIT : ST_RST_LOW;
        end else begin
            case (state_r)
                ST_PRES_WAIT: begin
                    if (phase_tmr_r >= PW_LAST_T) state_nx_s = ST_PRESENCE;
                    else                          state_nx_s = state_r;
                end
                ST_PRESENCE: begin
                    if (phase_tmr_r >= PRES_T) state_nx_s = ST_PRES_REL;
                    else                       state_nx_s = state_r;
                end
                ST_PRES_REL: begin
                    if (ow_s2_r) state_nx_s = ST_ROM_CMD;
                    else         state_nx_s = state_r;
                end
                ST_ROM_CMD: begin
                    if (samp_s && byte_last_s) begin
                        case (rx_word_s)
                            8'h33:   state_nx_s = ST_READ_ROM;
                            8'hCC:   state_nx_s = ST_FUNC;
                            8'h55:   state_nx_s = ST_MATCH_ROM;
                            default: state_nx_s = ST_IDLE;
                        endcase
                    end else begin
                        state_nx_s = state_r;
                    end
                end
                ST_READ_ROM: begin
                    if (samp_s && rom_last_s) state_nx_s = ST_FUNC;
                    else                      state_nx_s = state_r;
                end
                ST_MATCH_ROM: begin
                    if (samp_s && (ow_s2_r != rom_id[bit_cnt_r[5:0]])) state_nx_s = ST_IDLE;
                    else if (samp_s && rom_last_s)                    state_nx_s = ST_FUNC;
                    else                                              state_nx_s = state_r;
                end
                ST_IDLE, ST_RST_LOW, ST_FUNC: begin
                    state_nx_s = state_r;
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // Phase timer restarts at 1 on every state change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_tmr_r <= '0;
        end else if (state_nx_s != state_r) begin
            phase_tmr_r <= ONE_T;
        end else if (phase_tmr_r != PHASE_MAX_T) begin
            phase_tmr_r <= phase_tmr_r + ONE_T;
        end else begin
            phase_tmr_r <= phase_tmr_r;
        end
    end

    // Slot engine, bit/byte counters and shift registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_act_r <= 1'b0;
            armed_r    <= 1'b0;
            drv_r      <= 1'b0;
            edge_tmr_r <= SLOT_MAX_T;
            byte_act_r <= 1'b0;
            func_tx_r  <= 1'b0;
            bit_cnt_r  <= 7'd0;
            rx_sh_r    <= 7'd0;
            tx_sh_r    <= 8'd0;
        end else if (sat_s) begin
            slot_act_r <= 1'b0;
            armed_r    <= 1'b0;
            drv_r      <= 1'b0;
            edge_tmr_r <= SLOT_MAX_T;
            byte_act_r <= 1'b0;
            func_tx_r  <= 1'b0;
            bit_cnt_r  <= 7'd0;
        end else begin
            // A new slot needs the line to have been seen high after the last one.
            if (start_s)                     armed_r <= 1'b0;
            else if (!slot_act_r && ow_s2_r) armed_r <= 1'b1;
            if (start_s) begin
                slot_act_r <= 1'b1;
                edge_tmr_r <= ONE_T;
                drv_r      <= tx_slot_s & ~tx_bit_s;
            end else begin
                if (samp_s) slot_act_r <= 1'b0;
                if (edge_tmr_r != SLOT_MAX_T) edge_tmr_r <= edge_tmr_r + ONE_T;
            end
            if (latch_s) begin
                tx_sh_r    <= tx_byte;
                func_tx_r  <= 1'b1;
                byte_act_r <= 1'b1;
            end else if (start_s && (state_r == ST_FUNC) && !byte_act_r) begin
                func_tx_r  <= 1'b0;
                byte_act_r <= 1'b1;
            end
            if (samp_s) begin
                rx_sh_r <= rx_word_s[7:1];
                if ((state_r == ST_FUNC) && byte_last_s) byte_act_r <= 1'b0;
            end
            if (state_nx_s != state_r) begin
                bit_cnt_r <= 7'd0;
            end else if (samp_s) begin
                bit_cnt_r <= ((state_r == ST_FUNC) && byte_last_s) ? 7'd0 : bit_cnt_r + 7'd1;
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
        end
    end

    // Output decode; every output is registered below.
    always_comb begin
        oe_nx_s        = ~sat_s & ((state_nx_s == ST_PRESENCE) | drive_s);
        selected_nx_s  = (state_nx_s == ST_FUNC);
        bus_reset_nx_s = sat_s & rise_s;
        rx_dv_nx_s     = samp_s & (state_r == ST_FUNC) & ~func_tx_r & byte_last_s;
        tx_ready_nx_s  = latch_s;
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oe_r        <= 1'b0;
            selected_r  <= 1'b0;
            bus_reset_r <= 1'b0;
            rx_dv_r     <= 1'b0;
            tx_ready_r  <= 1'b0;
            rx_byte_r   <= 8'd0;
        end else begin
            oe_r        <= oe_nx_s;
            selected_r  <= selected_nx_s;
            bus_reset_r <= bus_reset_nx_s;
            rx_dv_r     <= rx_dv_nx_s;
            tx_ready_r  <= tx_ready_nx_s;
            if (rx_dv_nx_s) rx_byte_r <= rx_word_s;
            else            rx_byte_r <= rx_byte_r;
        end
    end

endmodule

// File: tb/tb_one_wire_slave.sv
// Bench for one_wire_slave: a behavioural bus master on a wired-AND line,
// table-driven function-phase bytes and a scoreboard for received bytes.
module tb_one_wire_slave;

    localparam int CPU      = 2;
    localparam int PW       = 30 * CPU;
    localparam int PRES     = 120 * CPU;
    localparam int TX0      = 45 * CPU;
    localparam int RST_LOW  = 480 * CPU;
    localparam int SLOT     = 70 * CPU;
    localparam int W0_LOW   = 60 * CPU;
    localparam int W1_LOW   = 6 * CPU;
    localparam int RD_LOW   = 6 * CPU;
    localparam int RD_SAMP  = 15 * CPU;

    logic        clk = 1'b0;
    logic        rst_n, m_low, ow_in;
    logic        ow_out, ow_oe, selected, bus_reset, rx_dv, tx_valid, tx_ready;
    logic [63:0] rom_id;
    logic [7:0]  rx_byte, tx_byte;

    int n_tests = 0, n_fail = 0;
    int rx_dv_cnt = 0, tx_ready_cnt = 0, bus_reset_cnt = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       rd;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;
    assign ow_in = ~(m_low | ow_oe);

    one_wire_slave #(.CLKS_PER_US(CPU)) dut (
        .clk(clk), .reset(rst_n), .ow_in(ow_in), .ow_out(ow_out), .ow_oe(ow_oe),
        .rom_id(rom_id), .selected(selected), .bus_reset(bus_reset),
        .rx_byte(rx_byte), .rx_dv(rx_dv), .tx_byte(tx_byte), .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every rx_dv must match the oldest byte the master wrote.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rx_dv) begin
            rx_dv_cnt++;
            if (rx_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rx_dv_unexpected: got rx_byte=0x%0h, required no rx_dv", rx_byte);
            end else begin
                e = rx_q.pop_front();
                check("rx_byte", {56'd0, rx_byte}, {56'd0, e});
            end
        end
        if (tx_ready)  tx_ready_cnt++;
        if (bus_reset) bus_reset_cnt++;
    end

    task automatic write_bit(input logic b);
        m_low = 1'b1;
        for (int i = 0; i < SLOT; i++) begin
            @(negedge clk);
            if (i == (b ? W1_LOW - 1 : W0_LOW - 1)) m_low = 1'b0;
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        for (int i = 0; i < 8; i++) write_bit(d[i]);
    endtask

    task automatic read_bit(output logic b, output int oe_len);
        oe_len = 0;
        b = 1'b0;
        m_low = 1'b1;
        for (int i = 0; i < SLOT; i++) begin
            @(negedge clk);
            if (i == RD_LOW - 1) m_low = 1'b0;
            if (i == RD_SAMP - 1) b = ow_in;
            if (ow_oe) oe_len++;
        end
    endtask

    task automatic read_bits(input int n, output logic [63:0] d, output int bad);
        logic b;
        int   len;
        d = 64'd0;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            read_bit(b, len);
            d[i] = b;
            if (len != (b ? 0 : TX0)) bad++;
        end
    endtask

    task automatic wait_tx_ready();
        int t = 0;
        while (!tx_ready && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("tx_ready_seen", {63'd0, tx_ready}, 64'd1);
        tx_valid = 1'b0;
    endtask

    task automatic bus_reset_seq();
        int oe_hi = 0, t = 0, d = 0, w = 0;
        int br0 = bus_reset_cnt;
        m_low = 1'b1;
        for (int i = 0; i < RST_LOW; i++) begin
            @(negedge clk);
            if (ow_oe) oe_hi++;
        end
        m_low = 1'b0;
        check("oe_during_reset_low", oe_hi, 0);
        while (!bus_reset && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("bus_reset_seen", {63'd0, bus_reset}, 64'd1);
        while (!ow_oe && d < PW + 50) begin
            @(negedge clk);
            d++;
        end
        check("presence_delay", d, PW - 1);
        while (ow_oe && w < PRES + 50) begin
            @(negedge clk);
            w++;
        end
        check("presence_width", w, PRES);
        repeat (20) @(negedge clk);
        check("bus_reset_pulses", bus_reset_cnt - br0, 1);
        check("selected_after_reset", {63'd0, selected}, 64'd0);
    endtask

    initial begin
        logic [63:0] got;
        int          bad, dv0, tr0, br0, hi, t;

        vecs[0] = '{data: 8'hA5, rd: 1'b0};
        vecs[1] = '{data: 8'h00, rd: 1'b0};
        vecs[2] = '{data: 8'h3C, rd: 1'b1};
        vecs[3] = '{data: 8'hFF, rd: 1'b0};
        vecs[4] = '{data: 8'h81, rd: 1'b1};
        vecs[5] = '{data: 8'h5A, rd: 1'b0};

        rst_n = 1'b0; m_low = 1'b0; tx_byte = 8'd0; tx_valid = 1'b0;
        rom_id = 64'h2800_0001_2345_6728;
        repeat (3) @(negedge clk);
        check("rst_ow_oe", {63'd0, ow_oe}, 64'd0);
        check("rst_ow_out", {63'd0, ow_out}, 64'd0);
        check("rst_selected", {63'd0, selected}, 64'd0);
        check("rst_flags", {61'd0, bus_reset, rx_dv, tx_ready}, 64'd0);
        check("rst_rx_byte", {56'd0, rx_byte}, 64'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Skip ROM then function bytes from the table.
        bus_reset_seq();
        write_byte(8'hCC);
        check("skip_selected", {63'd0, selected}, 64'd1);
        dv0 = rx_dv_cnt;
        tr0 = tx_ready_cnt;
        for (int i = 0; i < 6; i++) begin
            if (!vecs[i].rd) begin
                rx_q.push_back(vecs[i].data);
                write_byte(vecs[i].data);
            end else begin
                tx_exp_q.push_back(vecs[i].data);
                tx_byte = vecs[i].data;
                tx_valid = 1'b1;
                wait_tx_ready();
                read_bits(8, got, bad);
                check("read_byte", got, {56'd0, tx_exp_q.pop_front()});
                check("read_oe_shape", bad, 0);
            end
        end
        check("table_rx_dv_count", rx_dv_cnt - dv0, 4);
        check("table_tx_ready_count", tx_ready_cnt - tr0, 2);

        // Read ROM.
        bus_reset_seq();
        write_byte(8'h33);
        check("readrom_not_selected_yet", {63'd0, selected}, 64'd0);
        read_bits(64, got, bad);
        check("readrom_id", got, 64'h2800_0001_2345_6728);
        check("readrom_oe_shape", bad, 0);
        check("readrom_selected", {63'd0, selected}, 64'd1);

        // Match ROM with bit 63 wrong, then a write that must be ignored.
        bus_reset_seq();
        write_byte(8'h55);
        for (int i = 0; i < 64; i++) write_bit((i == 63) ? ~rom_id[i] : rom_id[i]);
        check("match_bad_selected", {63'd0, selected}, 64'd0);
        dv0 = rx_dv_cnt;
        write_byte(8'h5A);
        check("ignored_write_no_rx_dv", rx_dv_cnt - dv0, 0);
        bus_reset_seq();
        write_byte(8'hCC);
        check("recover_selected", {63'd0, selected}, 64'd1);
        rx_q.push_back(8'h96);
        write_byte(8'h96);

        // Transmit 0x3C, abort by a bus reset during the fourth slot.
        tr0 = tx_ready_cnt;
        tx_byte = 8'h3C;
        tx_valid = 1'b1;
        wait_tx_ready();
        read_bits(3, got, bad);
        check("abort_first_bits", got, 64'h4);
        check("abort_oe_shape", bad, 0);
        bus_reset_seq();
        check("abort_tx_ready_count", tx_ready_cnt - tr0, 1);

        // Chip reset in the middle of a presence pulse.
        br0 = bus_reset_cnt;
        m_low = 1'b1;
        repeat (RST_LOW) @(negedge clk);
        m_low = 1'b0;
        t = 0;
        while (!ow_oe && t < PW + 60) begin
            @(negedge clk);
            t++;
        end
        check("mid_presence_started", {63'd0, ow_oe}, 64'd1);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset_oe", {63'd0, ow_oe}, 64'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        hi = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (ow_oe) hi++;
        end
        check("no_presence_after_reset", hi, 0);
        check("mid_bus_reset_count", bus_reset_cnt - br0, 1);
        check("rx_queue_drained", rx_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
